// File: rtl/uart_tx_fifo.sv
//==============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered UART transmitter, 5..8 data bits, optional parity,
//            1/2 stop bits, run-time divisor. UART_TX_BREAK_EN adds i_break.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WID   = 16,
    parameter int FIFO_AW   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_wr,
    input  logic [DIV_WID-1:0]   i_div,
    input  logic [1:0]           i_par_mode,
    input  logic                 i_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_break,
`endif
    output logic                 o_uart_tx,
    output logic                 o_busy,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [FIFO_AW:0]     o_level,
    output logic                 o_overflow
);

    localparam logic [FIFO_AW:0] c_depth    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [3:0]       c_last_bit = 4'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] c_st_break  = 3'd5;
`endif

    logic [DATA_BITS-1:0] r_mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_level;
    logic                 r_overflow;

    logic [2:0]           r_state;
    logic                 r_tx;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic [DIV_WID-1:0]   r_div_cnt;
    logic [DIV_WID-1:0]   r_div;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_parity;
    logic                 r_stop2;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_frame_done;
    logic                 w_start_ok;
    logic [DATA_BITS-1:0] w_head;

    assign w_full       = (r_level == c_depth);
    assign w_empty      = (r_level == '0);
    assign w_push       = i_wr & ~w_full;
    assign w_bit_end    = (r_div_cnt == '0);
    assign w_frame_done = (r_state == c_st_stop) & w_bit_end & ~(r_stop2 & (r_bit_cnt == 4'd0));
    assign w_start_ok   = (r_state == c_st_idle) | w_frame_done;
    assign w_head       = r_mem[r_rd_ptr];

`ifdef UART_TX_BREAK_EN
    logic w_brk_enter;
    assign w_brk_enter = w_start_ok & i_break;
    assign w_pop       = w_start_ok & ~w_empty & ~i_break;
`else
    assign w_pop       = w_start_ok & ~w_empty;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_wr & w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (FIFO_AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (FIFO_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_st_idle;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_div     <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_parity  <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            if (r_state != c_st_idle && !w_bit_end) begin
                r_div_cnt <= r_div_cnt - DIV_WID'(1);
            end
            case (r_state)
                c_st_start: if (w_bit_end) begin
                    r_state   <= c_st_data;
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                    r_div_cnt <= r_div;
                end
                c_st_data: if (w_bit_end) begin
                    r_div_cnt <= r_div;
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt <= '0;
                        if (r_par_en) begin
                            r_state <= c_st_parity;
                            r_tx    <= r_parity ^ r_par_odd;
                        end else begin
                            r_state <= c_st_stop;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                c_st_parity: if (w_bit_end) begin
                    r_state   <= c_st_stop;
                    r_tx      <= 1'b1;
                    r_div_cnt <= r_div;
                end
                // r_bit_cnt marks the second stop bit when two are configured
                c_st_stop: if (w_bit_end) begin
                    if (r_stop2 && r_bit_cnt == 4'd0) begin
                        r_bit_cnt <= 4'd1;
                        r_div_cnt <= r_div;
                    end else begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
`ifdef UART_TX_BREAK_EN
                // Release reuses a single stop bit as the mandatory idle bit time
                c_st_break: if (!i_break) begin
                    r_state   <= c_st_stop;
                    r_tx      <= 1'b1;
                    r_div_cnt <= r_div;
                    r_bit_cnt <= '0;
                end
`endif
                default: ;
            endcase

            if (w_pop) begin
                r_state   <= c_st_start;
                r_tx      <= 1'b0;
                r_busy    <= 1'b1;
                r_shift   <= w_head;
                r_parity  <= ^w_head;
                r_div     <= i_div;
                r_div_cnt <= i_div;
                r_par_en  <= (i_par_mode == 2'b01) || (i_par_mode == 2'b10);
                r_par_odd <= (i_par_mode == 2'b10);
                r_stop2   <= i_stop2;
                r_bit_cnt <= '0;
            end
`ifdef UART_TX_BREAK_EN
            else if (w_brk_enter) begin
                r_state   <= c_st_break;
                r_tx      <= 1'b0;
                r_busy    <= 1'b1;
                r_div     <= i_div;
                r_div_cnt <= i_div;
                r_stop2   <= 1'b0;
                r_bit_cnt <= '0;
            end
`endif
        end
    end

    assign o_uart_tx  = r_tx;
    assign o_busy     = r_busy;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire
